fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline, upstream of decode. Holds PC, issues
//  req/ready fetches to instruction memory, applies decode-resolved branch redirects and

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if_id_pipe_reg.sv | 33 +++
 rtl/fetch_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its IF/ID pipeline register:
// NOP encoding, default reset vector and fetch FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    NORMAL     = 1'b0,
    REDIR_PEND = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_pipe_reg.sv
// Generic pipeline register between fetch and decode: reset and flush insert a
// bubble, stall holds the current contents, otherwise the new payload is loaded.
module if_id_pipe_reg
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    load_instr,
  input  logic [ADDRESS_WIDTH-1:0] load_pc_plus4,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     valid
);

  // Flush wins over stall so a redirect can squash a held slot.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      instr    <= DATA_WIDTH'(NOP_INSTR);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, req/ready fetch handshake, parked
// branch redirects, IF/ID register and a saturating fetch-wait counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                     CNT_WIDTH     = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_StallF,
  input  logic                     i_StallD,
  input  logic                     i_PCSrcD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCBranchD,
  output logic                     o_IMemReq,
  output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
  input  logic                     i_IMemReady,
  input  logic [DATA_WIDTH-1:0]    i_IMemRdata,
  output logic [ADDRESS_WIDTH-1:0] o_PCF,
  output logic [DATA_WIDTH-1:0]    o_InstrD,
  output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
  output logic                     o_ValidD,
  output logic [CNT_WIDTH-1:0]     o_FetchWaitCnt
);

  fetch_state_t             state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDRESS_WIDTH-1:0] tgt_reg, tgt_next;
  logic [CNT_WIDTH-1:0]     cnt_reg, cnt_next;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     redirect;
  logic                     ifid_flush;

  assign pc_plus4 = pc_reg + ADDRESS_WIDTH'(4);
  // A taken branch is only believed once decode holds a non-stalled instruction.
  assign redirect = i_PCSrcD && !i_StallD;

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_reg <= NORMAL;
      pc_reg    <= RESET_VECTOR;
      tgt_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      tgt_reg   <= tgt_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;

    unique case (state_reg)
      NORMAL: begin
        if (redirect && i_IMemReady) begin
          pc_next = i_PCBranchD;
        end else if (redirect) begin
          // PC must stay put while the fetch is outstanding; park the target.
          tgt_next   = i_PCBranchD;
          state_next = REDIR_PEND;
        end else if (!i_StallF && i_IMemReady) begin
          pc_next = pc_plus4;
        end
      end
      REDIR_PEND: begin
        if (i_IMemReady) begin
          pc_next    = tgt_reg;
          state_next = NORMAL;
        end
      end
      default: state_next = NORMAL;
    endcase

    if (!i_IMemReady && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
      cnt_next = cnt_reg + CNT_WIDTH'(1);
    end
  end

  // Bubble on redirect, on a wrong-path completion, or when nothing usable was fetched;
  // a decode stall without redirect simply holds the register.
  assign ifid_flush = redirect ||
                      (!i_StallD && !((state_reg == NORMAL) && i_IMemReady && !i_StallF));

  if_id_pipe_reg #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_if_id (
    .clk           (i_CLK),
    .rst_n         (i_RST),
    .stall         (i_StallD),
    .flush         (ifid_flush),
    .load_instr    (i_IMemRdata),
    .load_pc_plus4 (pc_plus4),
    .instr         (o_InstrD),
    .pc_plus4      (o_PCPlus4D),
    .valid         (o_ValidD)
  );

  assign o_IMemReq      = i_RST;
  assign o_IMemAddr     = pc_reg;
  assign o_PCF          = pc_reg;
  assign o_FetchWaitCnt = cnt_reg;

endmodule
